// File: rtl/muldiv_sequencer_if.sv
// Operand/result bundle between the control FSM and the multicycle MULT/DIV engine.
// The control FSM drives the request side; the engine drives status and results.
interface muldiv_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle signed MULT/DIV engine: shift-add multiply or restoring divide on
// operand magnitudes over WIDTH cycles, signs applied in a single FINISH cycle.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input logic              clock,
   input logic              reset,
   muldiv_sequencer_if.slave bus
);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned RW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned IW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_mag_q, a_mag_d;
   logic [WIDTH-1:0] b_mag_q, b_mag_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             op_div_q, op_div_d;
   logic             zero_q, zero_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] in_a_mag, in_b_mag;
   logic             last_iter;
   logic [PW-1:0]    mult_add;
   logic [RW-1:0]    rem_sh, rem_diff;
   logic [PW-1:0]    prod_signed;
   logic [WIDTH-1:0] quo_signed, rem_signed;

   // Magnitudes: |MIN| naturally lands on 2^(WIDTH-1) as an unsigned value
   assign in_a_mag  = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
   assign in_b_mag  = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
   assign last_iter = (cnt_q == CW'(WIDTH - 1));
   assign mult_add  = PW'(a_mag_q) << cnt_q[IW-1:0];

   // Restoring step: dividend bits shift in MSB-first from the quotient register
   assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
   assign rem_diff  = rem_sh - {1'b0, b_mag_q};

   assign prod_signed = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
   assign quo_signed  = (sign_a_q ^ sign_b_q) ? -quo_q  : quo_q;
   assign rem_signed  = sign_a_q ? -rem_q : rem_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt_q    <= '0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         op_div_q <= 1'b0;
         zero_q   <= 1'b0;
         prod_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state    <= state_next;
         cnt_q    <= cnt_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         op_div_q <= op_div_d;
         zero_q   <= zero_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_next = state;
      cnt_d      = cnt_q;
      a_mag_d    = a_mag_q;
      b_mag_d    = b_mag_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      op_div_d   = op_div_q;
      zero_d     = zero_q;
      prod_d     = prod_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dz_d       = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;

      unique case (state)
         IDLE: begin
            if (bus.start) begin
               a_mag_d  = in_a_mag;
               b_mag_d  = in_b_mag;
               sign_a_d = bus.operand_a[WIDTH-1];
               sign_b_d = bus.operand_b[WIDTH-1];
               op_div_d = bus.op;
               zero_d   = bus.op && (bus.operand_b == '0);
               cnt_d    = '0;
               prod_d   = '0;
               rem_d    = '0;
               quo_d    = in_a_mag;
               busy_d   = 1'b1;
               if (!bus.op)                     state_next = MULT;
               else if (bus.operand_b == '0)    state_next = FINISH;
               else                             state_next = DIV;
            end
         end
         MULT: begin
            if (b_mag_q[cnt_q[IW-1:0]]) prod_d = prod_q + mult_add;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) state_next = FINISH;
         end
         DIV: begin
            if (!rem_diff[WIDTH]) begin
               rem_d = rem_diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (last_iter) state_next = FINISH;
         end
         FINISH: begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_next = IDLE;
            if (zero_q) begin
               dz_d = 1'b1;
            end else if (op_div_q) begin
               hi_d = rem_signed;
               lo_d = quo_signed;
            end else begin
               hi_d = prod_signed[PW-1:WIDTH];
               lo_d = prod_signed[WIDTH-1:0];
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed MULT/DIV results, latency,
// pulse width, divide-by-zero, ignored starts, mid-op reset and back-to-back ops.
module tb_muldiv_sequencer;
   localparam int unsigned WIDTH = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

   muldiv_sequencer #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int edges, output int busy_cyc);
      edges = 0; busy_cyc = 0;
      while (bus.done !== 1'b1 && edges < 100) begin
         if (bus.busy === 1'b1) busy_cyc++;
         @(negedge clock);
         edges++;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", bus.done); end
      tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL reset_div_zero got %b expected 0", bus.div_zero); end
      tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin fails++; $display("FAIL reset_hilo got %h/%h expected 0/0", bus.hi, bus.lo); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_mult();
      logic [31:0] va [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'h0001_0000, 32'h7FFF_FFFF};
      logic [31:0] vb [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFA, 32'h0001_0000, 32'h7FFF_FFFF};
      logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0, 32'h1, 32'h3FFF_FFFF};
      logic [31:0] el [5] = '{32'hFFFF_FFEB, 32'h0, 32'h1E, 32'h0, 32'h1};
      int e, bc;
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, va[i], vb[i]);
         wait_done(e, bc);
         tests++; if (e !== 33) begin fails++; $display("FAIL mult%0d_latency got %0d expected 33", i, e); end
         tests++; if (bc !== 33) begin fails++; $display("FAIL mult%0d_busy_cycles got %0d expected 33", i, bc); end
         tests++; if (bus.hi !== eh[i] || bus.lo !== el[i]) begin
            fails++; $display("FAIL mult%0d_result got %h/%h expected %h/%h", i, bus.hi, bus.lo, eh[i], el[i]);
         end
         tests++; if (bus.busy !== 1'b0 || bus.div_zero !== 1'b0) begin
            fails++; $display("FAIL mult%0d_flags busy=%b dz=%b expected 0/0", i, bus.busy, bus.div_zero);
         end
         @(negedge clock);
         tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mult%0d_done_pulse got %b expected 0", i, bus.done); end
      end
   endtask

   task automatic test_div();
      logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'd100, 32'd7, 32'h8000_0000, 32'hFFFF_FF9C, 32'h8000_0000};
      logic [31:0] vb [6] = '{32'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'd2, 32'd1, 32'h0, 32'hFFFF_FFFE, 32'h0};
      logic [31:0] el [6] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'd1};
      int e, bc;
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, va[i], vb[i]);
         wait_done(e, bc);
         tests++; if (e !== 33) begin fails++; $display("FAIL div%0d_latency got %0d expected 33", i, e); end
         tests++; if (bus.hi !== eh[i] || bus.lo !== el[i]) begin
            fails++; $display("FAIL div%0d_result got %h/%h expected %h/%h", i, bus.hi, bus.lo, eh[i], el[i]);
         end
         tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL div%0d_div_zero got %b expected 0", i, bus.div_zero); end
         @(negedge clock);
         tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL div%0d_done_pulse got %b expected 0", i, bus.done); end
      end
   endtask

   task automatic test_div_zero();
      int e, bc;
      issue(1'b1, 32'd100, 32'd7);
      wait_done(e, bc);
      @(negedge clock);
      issue(1'b1, 32'd5, 32'd0);
      wait_done(e, bc);
      tests++; if (e !== 1) begin fails++; $display("FAIL dz_latency got %0d expected 1", e); end
      tests++; if (bc !== 1) begin fails++; $display("FAIL dz_busy_cycles got %0d expected 1", bc); end
      tests++; if (bus.div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b expected 1", bus.div_zero); end
      tests++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
         fails++; $display("FAIL dz_hilo_kept got %h/%h expected 2/e", bus.hi, bus.lo);
      end
      @(negedge clock);
      tests++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         fails++; $display("FAIL dz_pulse got done=%b dz=%b expected 0/0", bus.done, bus.div_zero);
      end
   endtask

   task automatic test_ignore_start();
      int e, bc;
      issue(1'b0, 32'd6, 32'd7);
      repeat (3) @(negedge clock);
      issue(1'b1, 32'd9, 32'd3);
      wait_done(e, bc);
      tests++; if (e + 4 !== 33) begin fails++; $display("FAIL ignore_latency got %0d expected 33", e + 4); end
      tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
         fails++; $display("FAIL ignore_result got %h/%h expected 0/2a", bus.hi, bus.lo);
      end
      @(negedge clock);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_no_queue busy got %b expected 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      issue(1'b0, 32'd6, 32'd7);
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
      tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         fails++; $display("FAIL rstmid_hilo got %h/%h expected 0/0", bus.hi, bus.lo);
      end
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
         @(negedge clock);
      end
      tests++; if (dones !== 0) begin fails++; $display("FAIL rstmid_no_done got %0d active cycles expected 0", dones); end
   endtask

   task automatic test_back_to_back();
      int e, bc, act = 0;
      issue(1'b0, 32'd3, 32'd4);
      wait_done(e, bc);
      tests++; if (e !== 33 || bus.lo !== 32'd12) begin
         fails++; $display("FAIL b2b_first got lat=%0d lo=%h expected 33/c", e, bus.lo);
      end
      issue(1'b1, 32'd100, 32'd7);
      wait_done(e, bc);
      tests++; if (e !== 33) begin fails++; $display("FAIL b2b_second_latency got %0d expected 33", e); end
      tests++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
         fails++; $display("FAIL b2b_second_result got %h/%h expected 2/e", bus.hi, bus.lo);
      end
      @(negedge clock);
      bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; bus.start = 1'b0;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_reset_busy got %b expected 0", bus.busy); end
      for (int i = 0; i < 40; i++) begin
         if (bus.busy === 1'b1 || bus.done === 1'b1) act++;
         @(negedge clock);
      end
      tests++; if (act !== 0) begin fails++; $display("FAIL start_reset_idle got %0d active cycles expected 0", act); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
